// File: rtl/tri_fu_csa_accum.sv
// Streaming unsigned accumulator kept in carry-save form (one 3:2 compression per beat),
// resolved by a chunked carry-propagate adder and presented under valid/ready.
module tri_fu_csa_accum #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GUARD = 8,
  parameter int unsigned CHUNK = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [WIDTH-1:0]         in_data_i,
  input  logic                     in_last_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [WIDTH+GUARD-1:0]   out_sum_o,
  output logic                     out_ovf_o
);

  localparam int unsigned ACC_WIDTH = WIDTH + GUARD;
  localparam int unsigned NCHUNK    = ACC_WIDTH / CHUNK;
  localparam int unsigned KW        = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    HOLD    = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   s_q, s_d;
  logic [ACC_WIDTH-1:0]   c_q, c_d;
  logic [ACC_WIDTH-1:0]   res_q, res_d;
  logic                   ovf_q, ovf_d;
  logic [KW-1:0]          k_q, k_d;
  logic                   cin_q, cin_d;
  logic                   out_valid_q, out_valid_d;

  logic                   accept;
  logic [ACC_WIDTH-1:0]   x_ext;
  logic [ACC_WIDTH-1:0]   csa_sum;
  logic [ACC_WIDTH-1:0]   csa_maj;
  logic [CHUNK-1:0]       s_chunk;
  logic [CHUNK-1:0]       c_chunk;
  logic [CHUNK:0]         chunk_add;
  logic                   last_chunk;

  assign in_ready_o = ((state_q == IDLE) || (state_q == ACCUM)) && !clear_i;
  assign accept     = in_valid_i && in_ready_o;

  // 3:2 compression of the running pair with the incoming operand
  assign x_ext   = ACC_WIDTH'(in_data_i);
  assign csa_sum = s_q ^ c_q ^ x_ext;
  assign csa_maj = (s_q & c_q) | (s_q & x_ext) | (c_q & x_ext);

  // Select chunk k of the redundant pair for this resolve cycle
  always_comb begin
    s_chunk = '0;
    c_chunk = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (k_q == KW'(i)) begin
        s_chunk = s_q[i*CHUNK +: CHUNK];
        c_chunk = c_q[i*CHUNK +: CHUNK];
      end
    end
  end

  assign chunk_add  = {1'b0, s_chunk} + {1'b0, c_chunk} + (CHUNK+1)'(cin_q);
  assign last_chunk = (k_q == KW'(NCHUNK - 1));

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    c_d         = c_q;
    res_d       = res_q;
    ovf_d       = ovf_q;
    k_d         = k_q;
    cin_d       = cin_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          s_d   = x_ext;
          c_d   = '0;
          ovf_d = 1'b0;
          if (in_last_i) begin
            state_d = RESOLVE;
            k_d     = '0;
            cin_d   = 1'b0;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          s_d   = csa_sum;
          c_d   = csa_maj << 1;
          // carry leaving the top of the carry vector is weight 2^ACC_WIDTH
          ovf_d = ovf_q | csa_maj[ACC_WIDTH-1];
          if (in_last_i) begin
            state_d = RESOLVE;
            k_d     = '0;
            cin_d   = 1'b0;
          end
        end
      end
      RESOLVE: begin
        for (int unsigned i = 0; i < NCHUNK; i++) begin
          if (k_q == KW'(i)) begin
            res_d[i*CHUNK +: CHUNK] = chunk_add[CHUNK-1:0];
          end
        end
        cin_d = chunk_add[CHUNK];
        k_d   = k_q + KW'(1);
        if (last_chunk) begin
          ovf_d       = ovf_q | chunk_add[CHUNK];
          k_d         = '0;
          state_d     = HOLD;
          out_valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (out_ready_i) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    // Flush wins over any handshake in the same cycle
    if (clear_i) begin
      state_d     = IDLE;
      s_d         = '0;
      c_d         = '0;
      res_d       = '0;
      ovf_d       = 1'b0;
      k_d         = '0;
      cin_d       = 1'b0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      s_q         <= '0;
      c_q         <= '0;
      res_q       <= '0;
      ovf_q       <= 1'b0;
      k_q         <= '0;
      cin_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      c_q         <= c_d;
      res_q       <= res_d;
      ovf_q       <= ovf_d;
      k_q         <= k_d;
      cin_q       <= cin_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_sum_o   = res_q;
  assign out_ovf_o   = ovf_q;

endmodule

// File: doc/tri_fu_csa_accum.md
# tri_fu_csa_accum

Parametrised, sequential successor to the single-bit 2:2 carry-save cell. It accumulates a stream of unsigned operands in redundant sum/carry form, using one 3:2 compression per accepted beat, so no carry propagates during accumulation. On the last beat it resolves the redundant pair with a multi-cycle chunked carry-propagate adder, then presents the result under a valid/ready handshake. It sits in the FU datapath wherever running sums are needed, such as partial-product or exponent-histogram accumulation.

## Interface
- WIDTH, 16: operand width in bits.
- GUARD, 8: guard bits added above WIDTH. ACC_WIDTH = WIDTH+GUARD.
- CHUNK, 8: bits resolved per cycle. ACC_WIDTH must be a multiple of CHUNK. NCHUNK = ACC_WIDTH/CHUNK.

- clk  in  1  Single clock, rising edge.
- rst  in  1  Synchronous, active-high reset.
- clear  in  1  Synchronous abort/flush. Takes priority over all handshakes.
- in_valid  in  1  Operand beat is valid.
- in_ready  out  1  Block accepts a beat. A beat transfers when in_valid & in_ready.
- in_data  in  WIDTH  Unsigned operand, zero-extended to ACC_WIDTH.
- in_last  in  1  Marks the final beat of a sequence.
- out_valid  out  1  Result is held.
- out_ready  in  1  Consumer takes the result.
- out_sum  out  ACC_WIDTH  Resolved sum mod 2^ACC_WIDTH.
- out_ovf  out  1  True sum of the sequence was ≥ 2^ACC_WIDTH.

## Operation
- State machine states: IDLE, ACCUM, RESOLVE, HOLD.
- Registers:
  - S, C: ACC_WIDTH each.
  - ovf: sticky.
  - chunk index k.
  - cin: resolve carry.
  - result register.
- in_ready = (IDLE | ACCUM) & ~clear. It is combinational from state and clear.
- Accepted beat, state IDLE: S = operand, C = 0, ovf = 0. Next state is ACCUM, or RESOLVE if in_last.
- Accepted beat, state ACCUM: S' = S^C^X. C' = ((S&C)|(S&X)|(C&X)) << 1.
  - The bit shifted out of the carry-vector MSB sets ovf.
  - If in_last, the next state is RESOLVE.
- No accepted beat in IDLE/ACCUM: state and registers hold.
- RESOLVE:
  - Entry sets k = 0 and cin = 0.
  - Each cycle, chunk k of the result = S[k] + C[k] + cin, where [k] denotes bits k*CHUNK..k*CHUNK+CHUNK-1. The chunk carry-out becomes cin.
  - k increments each cycle.
  - After chunk NCHUNK-1, its carry-out ORs into ovf and the next state is HOLD.
- HOLD: out_valid = 1, out_sum = result register, out_ovf = ovf. When out_ready is high, the next state is IDLE.
- Overflow is exact: true total = S + C + 2^ACC_WIDTH × (dropped carry bits + final carry-out). All terms are non-negative.
- clear:
  - In any state, the next state is IDLE.
  - S, C, ovf, k, cin and the result register are zeroed.
  - No beat is accepted in that cycle, and any held result is discarded.
- rst: same effect as clear.
- Reset values of outputs:
  - in_ready = 1.
  - out_valid = 0, out_sum = 0, out_ovf = 0.

## Timing
- Accumulation sustains 1 beat/cycle with no bubbles. A sequence of N beats occupies N accept cycles.
- Resolve latency:
  - The last beat is accepted at edge t.
  - RESOLVE occupies cycles t+1 .. t+NCHUNK.
  - out_valid is high from cycle t+NCHUNK+1. This is 4 cycles for the defaults.
- During RESOLVE and HOLD, in_ready = 0.
- After the HOLD handshake, the block is in IDLE the next cycle, and in_ready is high that cycle. There is no skid buffer.
- out_sum and out_ovf are registered and stable for the whole of HOLD.
- out_valid is never withdrawn without a handshake, except by clear or rst.
- A single-beat sequence (in_last on the first beat from IDLE) is legal, with the same latency.
- clear asserted in the same cycle as an in_last accept or an out handshake: clear wins, and the beat or result is dropped.

## Test plan
- Beats 0x0001, 0x0002, 0x0003 (last) back-to-back, out_ready=1 → out_valid rises 4 cycles after the last accept, with out_sum=0x000006, out_ovf=0, then in_ready returns.
- Beats 0x00FF, 0x0001 (last) → out_sum=0x000100. This checks the carry crossing the chunk 0→1 boundary.
- 257 beats of 0xFFFF (last on the 257th) → out_sum=0x00FEFF, out_ovf=1.
- Hold out_ready=0 for 10 cycles in HOLD → out_valid, out_sum and out_ovf stay stable and in_ready=0 throughout. Release → one-cycle handshake, then IDLE.
- Assert clear in the 2nd RESOLVE cycle → out_valid never rises. A following sequence 0x0005 (last) yields 0x000005.
- Assert rst mid-accumulation, with in_valid held high → all outputs take reset values, and no stale S/C leaks into the next sequence.
